// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and load/store access to one single-ported memory.
// Data has priority, and fetch is forced through after STARVE_MAX data grants in a row.
module mem_bus_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int unsigned BE_W       = DATA_W / 8;
   localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
   typedef enum logic [1:0] {OwnNone, OwnFetch, OwnData} owner_e;

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic [3:0]          starve_cnt_q, starve_cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic                data_wins;
   logic                gnt_ok;
   logic                rsp_ok;

   // Grants and responses are suppressed while reset is asserted so an
   // abandoned transaction never signals its requester.
   assign gnt_ok   = (state_q == StIssue) && mem_gnt && !rst;
   assign rsp_ok   = (state_q == StWait) && mem_rvalid && !rst;
   assign i_gnt    = gnt_ok && (owner_q == OwnFetch);
   assign d_gnt    = gnt_ok && (owner_q == OwnData);
   assign i_rvalid = rsp_ok && (owner_q == OwnFetch);
   assign d_rvalid = rsp_ok && (owner_q == OwnData);
   assign i_rdata  = (owner_q == OwnFetch) ? mem_rdata : '0;
   assign d_rdata  = (owner_q == OwnData) ? mem_rdata : '0;

   assign mem_req   = (state_q == StIssue);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;
   assign busy      = (state_q != StIdle);

   assign data_wins = d_req && !(i_req && (starve_cnt_q == STARVE_LIM));

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      unique case (state_q)
         StIdle: begin
            if (data_wins) begin
               owner_d = OwnData;
               we_d    = d_we;
               addr_d  = d_addr;
               wdata_d = d_wdata;
               be_d    = d_be;
               state_d = StIssue;
            end else if (i_req) begin
               owner_d = OwnFetch;
               we_d    = 1'b0;
               addr_d  = i_addr;
               wdata_d = '0;
               be_d    = '1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (mem_gnt) state_d = StWait;
         end
         StWait: begin
            if (mem_rvalid) begin
               state_d = StIdle;
               owner_d = OwnNone;
            end
         end
         default: begin
            state_d = StIdle;
            owner_d = OwnNone;
         end
      endcase
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!i_req) begin
         starve_cnt_d = '0;
      end else if (d_gnt) begin
         if (starve_cnt_q != STARVE_LIM) starve_cnt_d = starve_cnt_q + 4'd1;
      end else if (i_gnt) begin
         starve_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         owner_q      <= OwnNone;
         starve_cnt_q <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
      end
   end

endmodule
